// File: rtl/aesl_axis_block_sig_gen_if.sv
// rtl/aesl_axis_block_sig_gen_if.sv - stream observation and block-report bundle for the stall detector
interface aesl_axis_block_sig_gen_if #(
  parameter int NUM_CH = 1,
  parameter int IDX_W  = 1
);
  logic [NUM_CH-1:0] ch_tvalid;
  logic [NUM_CH-1:0] ch_tready;
  logic [NUM_CH-1:0] ch_is_input;
  logic              inst_idle;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic              first_blk_valid;
  logic [IDX_W-1:0]  first_blk_idx;

  modport master (
    output ch_tvalid, ch_tready, ch_is_input, inst_idle,
    input  axis_block_sigs, any_block, first_blk_valid, first_blk_idx
  );

  modport slave (
    input  ch_tvalid, ch_tready, ch_is_input, inst_idle,
    output axis_block_sigs, any_block, first_blk_valid, first_blk_idx
  );
endinterface

// File: rtl/aesl_axis_block_sig_gen.sv
// rtl/aesl_axis_block_sig_gen.sv - per-channel AXI-Stream stall detector with first-block latch
// Each channel counts consecutive stall cycles and raises its blocked flag once the threshold is reached.
module aesl_axis_block_sig_gen #(
  parameter int NUM_CH       = 1,
  parameter int STALL_THRESH = 16,
  parameter int CNT_W        = 16,
  parameter int IDX_W        = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  aesl_axis_block_sig_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BLOCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STALL_THRESH - 1);

  state_t            r_state     [NUM_CH];
  logic [CNT_W-1:0]  r_cnt       [NUM_CH];
  state_t            w_state_nxt [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt   [NUM_CH];

  logic [NUM_CH-1:0] w_stall;
  logic [NUM_CH-1:0] w_blk_nxt;
  logic [NUM_CH-1:0] w_enter;
  logic [IDX_W-1:0]  w_enter_idx;

  logic [NUM_CH-1:0] r_block_sigs;
  logic              r_any_block;
  logic              r_first_valid;
  logic [IDX_W-1:0]  r_first_idx;

  always_comb begin
    w_stall     = '0;
    w_blk_nxt   = '0;
    w_enter     = '0;
    w_enter_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      // Stall direction depends on who is supposed to move next on this stream
      if (bus.ch_is_input[i]) begin
        w_stall[i] = bus.ch_tready[i] & ~bus.ch_tvalid[i];
      end else begin
        w_stall[i] = bus.ch_tvalid[i] & ~bus.ch_tready[i];
      end

      if (bus.inst_idle) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
      end else begin
        case (r_state[i])
          S_IDLE: begin
            if (w_stall[i] && STALL_THRESH == 1) begin
              w_state_nxt[i] = S_BLOCK;
            end else if (w_stall[i]) begin
              w_state_nxt[i] = S_WAIT;
              w_cnt_nxt[i]   = CNT_W'(1);
            end
          end
          S_WAIT: begin
            if (w_stall[i] && r_cnt[i] == C_LAST) begin
              w_state_nxt[i] = S_BLOCK;
            end else if (w_stall[i]) begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end else begin
              w_state_nxt[i] = S_IDLE;
              w_cnt_nxt[i]   = '0;
            end
          end
          S_BLOCK: begin
            if (!w_stall[i]) begin
              w_state_nxt[i] = S_IDLE;
              w_cnt_nxt[i]   = '0;
            end
          end
          default: begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = '0;
          end
        endcase
      end

      w_blk_nxt[i] = (w_state_nxt[i] == S_BLOCK);
      w_enter[i]   = w_blk_nxt[i] && (r_state[i] != S_BLOCK);
    end

    // Descending scan so the lowest entering index is the one left standing
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_enter[i]) begin
        w_enter_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_block_sigs  <= '0;
      r_any_block   <= 1'b0;
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
    end else begin
      r_block_sigs <= w_blk_nxt;
      r_any_block  <= |w_blk_nxt;
      if (~|w_blk_nxt) begin
        r_first_valid <= 1'b0;
        r_first_idx   <= '0;
      end else if (!r_first_valid && |w_enter) begin
        r_first_valid <= 1'b1;
        r_first_idx   <= w_enter_idx;
      end
    end
  end

  assign bus.axis_block_sigs = r_block_sigs;
  assign bus.any_block       = r_any_block;
  assign bus.first_blk_valid = r_first_valid;
  assign bus.first_blk_idx   = r_first_idx;

endmodule

// File: tb/tb_aesl_axis_block_sig_gen.sv
// tb/tb_aesl_axis_block_sig_gen.sv - directed bench for the stall detector (threshold 4 and threshold 1 builds)
`timescale 1ns/1ps
module tb_aesl_axis_block_sig_gen;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  aesl_axis_block_sig_gen_if #(.NUM_CH(2), .IDX_W(1)) ifa ();
  aesl_axis_block_sig_gen_if #(.NUM_CH(1), .IDX_W(1)) ifb ();

  aesl_axis_block_sig_gen #(
    .NUM_CH(2), .STALL_THRESH(4), .CNT_W(16), .IDX_W(1)
  ) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa.slave)
  );

  aesl_axis_block_sig_gen #(
    .NUM_CH(1), .STALL_THRESH(1), .CNT_W(16), .IDX_W(1)
  ) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic check_a(input string tag, input logic [1:0] e_sigs, input logic e_any,
                         input logic e_valid, input logic e_idx);
    vectors++;
    assert (ifa.axis_block_sigs === e_sigs) else begin
      miscompares++;
      $error("FAIL %s.sigs observed=%b expected=%b", tag, ifa.axis_block_sigs, e_sigs);
    end
    vectors++;
    assert (ifa.any_block === e_any) else begin
      miscompares++;
      $error("FAIL %s.any observed=%b expected=%b", tag, ifa.any_block, e_any);
    end
    vectors++;
    assert (ifa.first_blk_valid === e_valid) else begin
      miscompares++;
      $error("FAIL %s.valid observed=%b expected=%b", tag, ifa.first_blk_valid, e_valid);
    end
    vectors++;
    assert (ifa.first_blk_idx === e_idx) else begin
      miscompares++;
      $error("FAIL %s.idx observed=%b expected=%b", tag, ifa.first_blk_idx, e_idx);
    end
  endtask

  task automatic check_b(input string tag, input logic e_sig, input logic e_valid);
    vectors++;
    assert (ifb.axis_block_sigs === e_sig) else begin
      miscompares++;
      $error("FAIL %s.sig observed=%b expected=%b", tag, ifb.axis_block_sigs, e_sig);
    end
    vectors++;
    assert (ifb.first_blk_valid === e_valid) else begin
      miscompares++;
      $error("FAIL %s.valid observed=%b expected=%b", tag, ifb.first_blk_valid, e_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    ifa.ch_tvalid = 2'b00; ifa.ch_tready = 2'b00; ifa.ch_is_input = 2'b10; ifa.inst_idle = 1'b0;
    ifb.ch_tvalid = 1'b0;  ifb.ch_tready = 1'b0;  ifb.ch_is_input = 1'b0;  ifb.inst_idle = 1'b0;
    repeat (2) @(negedge clock);
    check_a("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    check_b("reset_b", 1'b0, 1'b0);
    reset = 1'b0;

    // ch0 output stream stalls: flag on the 4th edge, not the 3rd
    ifa.ch_tvalid = 2'b01; ifa.ch_tready = 2'b00;
    tick(3);
    check_a("t1_edge3", 2'b00, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_a("t1_edge4", 2'b01, 1'b1, 1'b1, 1'b0);
    ifa.ch_tvalid = 2'b00;
    tick(1);
    check_a("t1_clear", 2'b00, 1'b0, 1'b0, 1'b0);

    // tready pulse on the third cycle restarts the count
    ifa.ch_tvalid = 2'b01;
    tick(2);
    ifa.ch_tready = 2'b01;
    tick(1);
    ifa.ch_tready = 2'b00;
    tick(1);
    check_a("t2_edge4", 2'b00, 1'b0, 1'b0, 1'b0);
    tick(2);
    check_a("t2_edge6", 2'b00, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_a("t2_edge7", 2'b01, 1'b1, 1'b1, 1'b0);
    ifa.ch_tvalid = 2'b00;
    tick(1);

    // ch0 output and ch1 input stall together: lowest index wins
    ifa.ch_tvalid = 2'b01; ifa.ch_tready = 2'b10;
    tick(4);
    check_a("t3_both", 2'b11, 1'b1, 1'b1, 1'b0);
    ifa.ch_tvalid = 2'b00;
    tick(1);
    check_a("t3_rel0", 2'b10, 1'b1, 1'b1, 1'b0);
    ifa.ch_tready = 2'b00;
    tick(1);
    check_a("t3_clear", 2'b00, 1'b0, 1'b0, 1'b0);

    // ch1 blocks first, ch0 two edges later: latch keeps idx 1
    ifa.ch_tready = 2'b10;
    tick(2);
    ifa.ch_tvalid = 2'b01;
    tick(2);
    check_a("t4_ch1", 2'b10, 1'b1, 1'b1, 1'b1);
    tick(2);
    check_a("t4_ch0", 2'b11, 1'b1, 1'b1, 1'b1);
    ifa.ch_tvalid = 2'b00; ifa.ch_tready = 2'b00;
    tick(1);
    check_a("t4_clear", 2'b00, 1'b0, 1'b0, 1'b0);

    // inst_idle overrides a standing stall, count restarts after it drops
    ifa.ch_tvalid = 2'b01;
    tick(4);
    check_a("t5_block", 2'b01, 1'b1, 1'b1, 1'b0);
    ifa.inst_idle = 1'b1;
    tick(1);
    check_a("t5_idle", 2'b00, 1'b0, 1'b0, 1'b0);
    ifa.inst_idle = 1'b0;
    tick(3);
    check_a("t5_edge3", 2'b00, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_a("t5_edge4", 2'b01, 1'b1, 1'b1, 1'b0);

    // asynchronous reset between edges clears at once
    #2 reset = 1'b1;
    #1;
    check_a("t6_async", 2'b00, 1'b0, 1'b0, 1'b0);
    ifa.ch_tvalid = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    tick(1);
    check_a("t6_after", 2'b00, 1'b0, 1'b0, 1'b0);

    // threshold-1 build: one stall edge is enough
    ifb.ch_tvalid = 1'b1;
    tick(1);
    check_b("t7_one", 1'b1, 1'b1);
    ifb.ch_tvalid = 1'b0;
    tick(1);
    check_b("t7_clear", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aesl_axis_block_sig_gen.md
Name: aesl_axis_block_sig_gen

Overview:
- Per-channel AXI-Stream stall detector for the HLS co-simulation harness.
- Drives the axis_block_sigs vector consumed by the per-instance deadlock monitors.
- Watches tvalid/tready on every DUT stream port and flags a channel as blocked once it has stalled for STALL_THRESH consecutive cycles.
- Also reports which channel blocked first, for the deadlock diagnostic printout.

Parameters:
- NUM_CH, 1: number of monitored AXI-Stream channels (>=1).
- STALL_THRESH, 16: consecutive stall cycles before a channel is declared blocked (>=1).
- CNT_W, 16: stall counter width; must hold STALL_THRESH-1.
- IDX_W, 1: width of the channel index output, = max(1, clog2(NUM_CH)).

Ports:
- clock  input  1  design clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ch_tvalid  input  NUM_CH  tvalid of each monitored stream.
- ch_tready  input  NUM_CH  tready of each monitored stream.
- ch_is_input  input  NUM_CH  static per channel: 1 = DUT reads this stream, 0 = DUT writes it.
- inst_idle  input  1  DUT instance idle; forces all channels unblocked.
- axis_block_sigs  output  NUM_CH  per-channel blocked flag, registered.
- any_block  output  1  OR of axis_block_sigs, registered.
- first_blk_valid  output  1  first_blk_idx holds a valid channel index.
- first_blk_idx  output  IDX_W  lowest-index channel of the first group to enter BLOCK.

Behaviour:
- Stall condition, per channel i, combinational:
  - Input stream (ch_is_input=1): stall_i = ch_tready & ~ch_tvalid.
  - Output stream (ch_is_input=0): stall_i = ch_tvalid & ~ch_tready.
  - A transfer (tvalid & tready) or both low is never a stall.
- Per-channel state machine, registered:
  - IDLE: cnt=0, flag low. If stall_i is sampled and STALL_THRESH==1, go to BLOCK. Else if stall_i is sampled, go to WAIT with cnt=1.
  - WAIT: if stall_i is sampled and cnt==STALL_THRESH-1, go to BLOCK. Else if stall_i is sampled, cnt+1. Else go to IDLE with cnt=0.
  - BLOCK: axis_block_sigs[i]=1. If stall_i is not sampled, go to IDLE with cnt=0 and the flag falls at that edge. Otherwise stay.
- Latency:
  - Flag rises on the edge that samples the STALL_THRESH-th consecutive stall cycle.
  - Flag falls on the first edge that samples no stall. There is no hysteresis.
- inst_idle=1 sampled: all channels go to IDLE and cnt=0 on that edge. This overrides stall.
- Counter never wraps. It cannot exceed STALL_THRESH-1 because BLOCK does not count.
- any_block: registered; equals the OR of the next-state flags, so it is aligned with axis_block_sigs.
- First-block latch:
  - When first_blk_valid=0 and at least one channel enters BLOCK on an edge, set first_blk_valid=1.
  - first_blk_idx = lowest index among the channels entering BLOCK on that edge (simultaneous entry: lowest index wins).
  - While first_blk_valid=1, the latch holds even if other channels block later.
  - Latch clears (valid=0, idx=0) on the edge where the next-state of every channel is non-BLOCK.
- Reset: asynchronous assert and synchronous-to-clock release. All states go to IDLE, cnt=0.
  - Output reset values: axis_block_sigs=0, any_block=0, first_blk_valid=0, first_blk_idx=0.
  - Reset asserted mid-WAIT or mid-BLOCK clears immediately, without waiting for a clock edge.
- ch_is_input is treated as static; behaviour if it changes while the channel is in WAIT/BLOCK is undefined.

Test Plan:
- NUM_CH=2, STALL_THRESH=4, ch0 output stream, tvalid=1 tready=0 from cycle 0 -> axis_block_sigs=01 after the 4th edge (not the 3rd); any_block=1; first_blk_valid=1; idx=0.
- Same setup, tready pulses high on cycle 2 -> counter restarts; flag needs 4 further stall edges; no block at edge 4.
- ch0 and ch1 (input stream: tready=1 tvalid=0) stall from the same cycle -> axis_block_sigs=11 on the same edge; first_blk_idx=0. Release ch0 only -> 10 next edge; first_blk latch stays idx=0, valid=1.
- ch1 blocks at edge 4, ch0 blocks at edge 6 -> first_blk_idx=1 retained; all stalls removed -> flags, any_block and first_blk_valid all 0 on the next edge.
- Channel in BLOCK, inst_idle=1 for one cycle with stall still present -> flag 0 on that edge; flag re-asserts 4 edges after inst_idle drops.
- reset asserted asynchronously mid-BLOCK between edges -> all outputs 0 immediately. STALL_THRESH=1 build: a single stall edge asserts the flag.
